// File: rtl/ram18_port_arb_pkg.sv
// ram18_arb_pkg: shared widths, arbiter state type and flattened-field extraction for ram18_port_arb
package ram18_arb_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int PAR_W = 2;
  localparam int FLAT_W = 8 * DATA_W;
  typedef enum logic {IDLE, LOCKED} state_t;
  function automatic logic [DATA_W-1:0] get_field(input logic [FLAT_W-1:0] vec, input int idx, input int w);
    logic [FLAT_W-1:0] m;
    m = (FLAT_W'(1) << w) - FLAT_W'(1);
    return DATA_W'((vec >> (idx * w)) & m);
  endfunction
endpackage

// File: rtl/ram18_port_arb_if.sv
// ram18_port_arb_if: requester bus (req/we/lock/addr/di/dip in, gnt/rd_valid/rd_data out); master=clients, slave=arbiter
interface ram18_port_arb_if import ram18_arb_pkg::*; #(parameter int NREQ = 4);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] we;
  logic [NREQ-1:0] lock;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] di;
  logic [NREQ*PAR_W-1:0] dip;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] rd_valid;
  logic [DATA_W+PAR_W-1:0] rd_data;
  modport master (output req, we, lock, addr, di, dip, input gnt, rd_valid, rd_data);
  modport slave (input req, we, lock, addr, di, dip, output gnt, rd_valid, rd_data);
endinterface

// File: rtl/ram18_port_arb_rr_pick.sv
// rr_pick: combinational round-robin picker; in req/ptr, out one-hot gnt, winner index, any
module rr_pick #(
  parameter int NREQ = 4,
  localparam int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   winner,
  output logic            any
);
  always_comb begin
    winner = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        winner = PW'(idx);
        any = 1'b1;
      end
    end
    gnt = any ? NREQ'(1) << winner : '0;
  end
endmodule

// File: rtl/ram18_port_arb.sv
// ram18_port_arb: round-robin arbiter with locked bursts sharing one 1Kx18 RAM port; clk/rst, requester bus (slave), o_ram_* to RAM, i_ram_do/dop back
module ram18_port_arb import ram18_arb_pkg::*; #(
  parameter int NREQ = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  ram18_port_arb_if.slave   bus,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic              o_ram_ssr,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_di,
  output logic [PAR_W-1:0]  o_ram_dip,
  input  logic [DATA_W-1:0] i_ram_do,
  input  logic [PAR_W-1:0]  i_ram_dop
);
  localparam int PW = $clog2(NREQ);
  state_t r_state;
  logic [PW-1:0] r_ptr, r_owner, w_pick_idx, w_win, w_ptr_nxt;
  logic [NREQ-1:0] w_pick_gnt, w_gnt, r_rd_valid;
  logic w_pick_any, w_any;
  logic [4:0] r_bcnt;
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req(bus.req), .ptr(r_ptr), .gnt(w_pick_gnt), .winner(w_pick_idx), .any(w_pick_any)
  );
  always_comb begin
    w_win = r_state == IDLE ? w_pick_idx : r_owner;
    w_gnt = rst ? '0 : r_state == IDLE ? w_pick_gnt : bus.req[r_owner] ? NREQ'(1) << r_owner : '0;
    w_any = |w_gnt;
    w_ptr_nxt = w_pick_idx == PW'(NREQ - 1) ? '0 : w_pick_idx + 1'b1;
    bus.gnt = w_gnt;
    bus.rd_valid = r_rd_valid & {NREQ{!rst}};
    bus.rd_data = {i_ram_dop, i_ram_do};
    o_ram_en = w_any;
    o_ram_we = w_any && bus.we[w_win];
    o_ram_ssr = 1'b0;
    o_ram_addr = w_any ? ADDR_W'(get_field(FLAT_W'(bus.addr), int'(w_win), ADDR_W)) : '0;
    o_ram_di = w_any ? get_field(FLAT_W'(bus.di), int'(w_win), DATA_W) : '0;
    o_ram_dip = w_any ? PAR_W'(get_field(FLAT_W'(bus.dip), int'(w_win), PAR_W)) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_owner <= '0;
      r_bcnt <= '0;
      r_rd_valid <= '0;
    end else begin
      r_rd_valid <= w_gnt & ~bus.we;
      if (r_state == IDLE) begin
        if (w_pick_any) begin
          r_ptr <= w_ptr_nxt;
          if (bus.lock[w_pick_idx] && MAX_BURST > 1) begin
            r_state <= LOCKED;
            r_owner <= w_pick_idx;
            r_bcnt <= 5'd1;
          end
        end
      end else if (bus.req[r_owner]) begin
        r_bcnt <= r_bcnt + 5'd1;
        if (!bus.lock[r_owner] || r_bcnt + 5'd1 == 5'(MAX_BURST)) r_state <= IDLE;
      end else begin
        r_state <= IDLE;
      end
    end
  end
endmodule

// File: doc/ram18_port_arb.md
Name: ram18_port_arb

Overview:
- Round-robin arbiter that shares one port of a 1K x 18 dual-port block RAM (10-bit address, 16 data bits plus 2 parity bits) between NREQ requesters.
- Each transfer is either a read or a write.
- Supports short locked bursts, so a requester can keep the port for consecutive accesses.
- Returns read data tagged with the requester's ID, one cycle after the access is accepted.
- Sits between client engines and the RAM primitive; the other RAM port is untouched.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_BURST, 8, maximum consecutive accesses per lock (1..16).

Ports:
- CLK  in  1  clock; the RAM port is clocked from the same net.
- RST  in  1  synchronous, active-high reset.
- REQ  in  NREQ  per-requester request.
- WE  in  NREQ  per-requester write enable (0 = read).
- LOCK  in  NREQ  keep the grant after this access.
- ADDR  in  NREQ*10  flattened addresses; requester i uses [i*10+:10].
- DI  in  NREQ*16  flattened write data.
- DIP  in  NREQ*2  flattened write parity.
- GNT  out  NREQ  one-hot grant (combinational).
- RD_VALID  out  NREQ  one-hot read-data strobe (registered).
- RD_DATA  out  18  {RAM_DOP, RAM_DO}, pass-through.
- RAM_EN  out  1  RAM port enable.
- RAM_WE  out  1  RAM port write enable.
- RAM_SSR  out  1  tied 0.
- RAM_ADDR  out  10  RAM address.
- RAM_DI  out  16  RAM write data.
- RAM_DIP  out  2  RAM write parity.
- RAM_DO  in  16  RAM read data.
- RAM_DOP  in  2  RAM read parity.

Behaviour:
- Reset: ptr=0, state=IDLE, owner=0, bcnt=0, RD_VALID=0. GNT=0 and RAM_EN=0 while RST=1, regardless of REQ.
- Handshake:
  - A requester holds REQ and its payload stable until it sees GNT.
  - Accept = REQ[i] & GNT[i] in the same cycle.
  - At most one GNT bit is set per cycle.
  - GNT never asserts without the matching REQ.
- RAM mux:
  - RAM_EN = |GNT.
  - RAM_WE, RAM_ADDR, RAM_DI and RAM_DIP are the winner's fields.
  - When idle, RAM_WE=0 and the other fields are 0.
- Read latency: for a read accepted in cycle t, RD_VALID[i]=1 in cycle t+1 with RD_DATA valid; the read tag is registered. A write never asserts RD_VALID.
- State IDLE (arbitrate):
  - Winner is the first REQ bit at or after ptr, scanning upward modulo NREQ.
  - On accept: ptr <= winner+1 mod NREQ.
  - If LOCK[winner]=1 and MAX_BURST>1: state <= LOCKED, owner <= winner, bcnt <= 1.
- State LOCKED (only owner may be granted):
  - REQ[owner]=1: grant owner and increment bcnt.
    - Return to IDLE after this accept if LOCK[owner]=0 or bcnt+1==MAX_BURST.
    - ptr stays at owner+1.
  - REQ[owner]=0: no grant this cycle; state <= IDLE at the next edge. This costs one idle cycle and is required.
- Burst cap: a requester holding LOCK gets exactly MAX_BURST consecutive grants. It then loses priority to any other pending requester.
- Fairness: with all REQ high and LOCK low, grants rotate 0,1,...,NREQ-1 and each requester waits at most NREQ-1 cycles.
- Reset mid-burst:
  - State returns to IDLE and ptr to 0.
  - An RD_VALID pending from the cycle before reset is suppressed, because RST wins over the tag register.

Decomposition:
- Package ram18_arb_pkg holds:
  - Constants ADDR_W=10, DATA_W=16, PAR_W=2.
  - State enum {IDLE, LOCKED}.
  - A function that extracts requester i's field from a flattened vector.
- One sub-module, rr_pick: a combinational round-robin picker.
  - Inputs: req[NREQ], ptr.
  - Outputs: one-hot gnt, winner index, any.
  - Used in IDLE; LOCKED overrides it with the owner.

Test Plan:
- Reset with REQ=4'b1111 held → GNT=0 and RAM_EN=0 during RST. First cycle after release: GNT=4'b0001. Following cycles: 0010, 0100, 1000, 0001.
- Requester 2 writes ADDR=10'h155, DI=16'hA5A5, DIP=2'b10, then reads 10'h155 → RAM_WE=1 on the write accept. On the read, RD_VALID=4'b0100 exactly one cycle after the read accept, with RD_DATA=18'h2A5A5.
- Requester 1 holds LOCK=1 and REQ=1 with REQ=4'b1111 and MAX_BURST=8 → 8 consecutive GNT=4'b0010, then GNT=4'b0100.
- Requester 0 locks, then drops REQ while others request → one cycle with GNT=0, then GNT=4'b0010.
- RST asserted in the cycle after a read accept → RD_VALID stays 0. First grant after release goes to the lowest pending index.
- Single requester 3 issuing back-to-back reads at 10'h000..10'h3FF → one accept per cycle, and the address wraps to 10'h000 without a gap.
